// File: rtl/fetch_stage_if.sv
// fetch_stage_if: EX-side control, ROM port and decoded EX outputs of the fetch stage (FETCH_INSTR_CNT_EN adds instr_cnt_EX)
interface fetch_stage_if #(parameter int IMEM_AW = 12);
    logic               stall_EX;
    logic               redirect_EX;
    logic [31:0]        redirect_pc_EX;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic [31:0]        pc_EX;
    logic [31:0]        instr_EX;
    logic               valid_EX;
    logic [6:0]         op_EX;
    logic [2:0]         funct3_EX;
    logic [6:0]         funct7_EX;
    logic [11:0]        imm12_EX;
    logic [19:0]        imm20_EX;
    logic               trap_EX;
`ifdef FETCH_INSTR_CNT_EN
    logic [31:0]        instr_cnt_EX;
`endif
    modport master (
`ifdef FETCH_INSTR_CNT_EN
        output instr_cnt_EX,
`endif
        input  stall_EX, redirect_EX, redirect_pc_EX, imem_rdata,
        output imem_addr, pc_EX, instr_EX, valid_EX, op_EX, funct3_EX,
        output funct7_EX, imm12_EX, imm20_EX, trap_EX
    );
    modport slave (
`ifdef FETCH_INSTR_CNT_EN
        input  instr_cnt_EX,
`endif
        output stall_EX, redirect_EX, redirect_pc_EX, imem_rdata,
        input  imem_addr, pc_EX, instr_EX, valid_EX, op_EX, funct3_EX,
        input  funct7_EX, imm12_EX, imm20_EX, trap_EX
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: single-issue instruction fetch with stall replay, zero-bubble redirect and misalignment trap (FETCH_INSTR_CNT_EN adds an issue counter)
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);
    typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;
    localparam logic [31:0] NOP = 32'h0000_0013;
    state_t      state_q, state_d;
    logic        arm_q;
    logic [31:0] pc_f_q, pc_f_d, pc_ex_q, pc_ex_d;
    logic        valid_q, valid_d, trap_q, trap_d;
    logic [31:0] instr;
    // next fetch/EX state; stall beats redirect, misaligned redirect traps
    always_comb begin
        state_d = state_q;
        pc_f_d  = pc_f_q;
        pc_ex_d = pc_ex_q;
        valid_d = valid_q;
        trap_d  = trap_q;
        case (state_q)
            BOOT: if (arm_q) begin
                state_d = RUN;
                pc_ex_d = RESET_PC;
                pc_f_d  = RESET_PC + 32'd4;
                valid_d = 1'b1;
            end
            RUN: if (!bus.stall_EX) begin
                if (bus.redirect_EX && |bus.redirect_pc_EX[1:0]) begin
                    state_d = TRAP;
                    valid_d = 1'b0;
                    trap_d  = 1'b1;
                end else begin
                    pc_ex_d = bus.redirect_EX ? bus.redirect_pc_EX : pc_f_q;
                    pc_f_d  = (bus.redirect_EX ? bus.redirect_pc_EX : pc_f_q) + 32'd4;
                    valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end
    // arm_q delays BOOT exit by one edge so the ROM sees RESET_PC for a full cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            arm_q   <= 1'b0;
            pc_f_q  <= RESET_PC;
            pc_ex_q <= RESET_PC;
            valid_q <= 1'b0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            arm_q   <= 1'b1;
            pc_f_q  <= pc_f_d;
            pc_ex_q <= pc_ex_d;
            valid_q <= valid_d;
            trap_q  <= trap_d;
        end
    end
    assign bus.imem_addr = bus.stall_EX    ? pc_ex_q[IMEM_AW+1:2] :
                           bus.redirect_EX ? bus.redirect_pc_EX[IMEM_AW+1:2] :
                                             pc_f_q[IMEM_AW+1:2];
    assign instr         = valid_q ? bus.imem_rdata : NOP;
    assign bus.instr_EX  = instr;
    assign bus.pc_EX     = pc_ex_q;
    assign bus.valid_EX  = valid_q;
    assign bus.trap_EX   = trap_q;
    assign bus.op_EX     = instr[6:0];
    assign bus.funct3_EX = instr[14:12];
    assign bus.funct7_EX = instr[31:25];
    assign bus.imm12_EX  = instr[31:20];
    assign bus.imm20_EX  = instr[31:12];
`ifdef FETCH_INSTR_CNT_EN
    logic [31:0] cnt_q;
    // counts instructions leaving EX; valid_q is low in TRAP so it freezes there
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 32'd0;
        else if (valid_q && !bus.stall_EX) cnt_q <= cnt_q + 32'd1;
    end
    assign bus.instr_cnt_EX = cnt_q;
`endif
endmodule
